// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: EX and LSU writeback requests, load scoreboard
// issue/lookup, and the registered register-file write port.
interface rf_wb_arbiter_if;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        ex_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic        ld_issue_ready;
   logic [4:0]  rs1_raddr;
   logic [4:0]  rs2_raddr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        wen;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;

   modport slave (
      input  ex_valid, ex_rd, ex_data, lsu_valid, lsu_rd, lsu_data,
             ld_issue, ld_rd, rs1_raddr, rs2_raddr,
      output ex_ready, lsu_ready, ld_issue_ready, rs1_busy, rs2_busy,
             wen, rd_waddr, rd_wdata
   );

   modport master (
      output ex_valid, ex_rd, ex_data, lsu_valid, lsu_rd, lsu_data,
             ld_issue, ld_rd, rs1_raddr, rs2_raddr,
      input  ex_ready, lsu_ready, ld_issue_ready, rs1_busy, rs2_busy,
             wen, rd_waddr, rd_wdata
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between EX and LSU
// writeback (LSU priority, EX forced through after MAX_WAIT refusals) and
// tracks outstanding loads per register so ID can stall on busy sources.
// Optional build macro RF_WB_SKID_EN: one-entry skid buffer on the EX port.
module rf_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned NREG     = 32
) (
   input  logic           clk,
   input  logic           rstn,
   rf_wb_arbiter_if.slave bus
);
   localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

   logic            w_ex_req;
   logic [4:0]      w_ex_rd;
   logic [31:0]     w_ex_data;
   logic            w_ex_pri;
   logic            w_gnt_ex;
   logic            w_gnt_lsu;
   logic [3:0]      r_wait;

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic [NREG-1:0] w_ld_oh;
   logic [NREG-1:0] w_lsu_oh;
   logic            w_ld_ready;
   logic            w_ld_set;

   logic            r_wen;
   logic [4:0]      r_waddr;
   logic [31:0]     r_wdata;

`ifdef RF_WB_SKID_EN
   logic            r_skid_full;
   logic [4:0]      r_skid_rd;
   logic [31:0]     r_skid_data;

   // EX source: the buffered entry is older than the live port, so it competes first
   always_comb begin
      w_ex_req  = r_skid_full | bus.ex_valid;
      w_ex_rd   = r_skid_full ? r_skid_rd   : bus.ex_rd;
      w_ex_data = r_skid_full ? r_skid_data : bus.ex_data;
   end

   // Skid buffer: capture a refused live request, release it once it wins a grant
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_skid_full <= 1'b0;
         r_skid_rd   <= '0;
         r_skid_data <= '0;
      end else if (r_skid_full) begin
         if (w_gnt_ex) r_skid_full <= 1'b0;
      end else if (bus.ex_valid && !w_gnt_ex) begin
         r_skid_full <= 1'b1;
         r_skid_rd   <= bus.ex_rd;
         r_skid_data <= bus.ex_data;
      end
   end

   assign bus.ex_ready = rstn & ~r_skid_full;
`else
   assign w_ex_req     = bus.ex_valid;
   assign w_ex_rd      = bus.ex_rd;
   assign w_ex_data    = bus.ex_data;
   assign bus.ex_ready = w_gnt_ex;
`endif

   // Arbitration: starved EX first, then LSU, then EX; nothing granted in reset
   always_comb begin
      w_ex_pri  = w_ex_req && (r_wait == 4'(MAX_WAIT));
      w_gnt_ex  = rstn && w_ex_req && (w_ex_pri || !bus.lsu_valid);
      w_gnt_lsu = rstn && bus.lsu_valid && !w_ex_pri;
   end

   assign bus.lsu_ready = w_gnt_lsu;

   // Starvation counter: counts refused EX cycles, saturates, clears on EX grant
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wait <= '0;
      end else if (w_gnt_ex) begin
         r_wait <= '0;
      end else if (w_ex_req && (r_wait != 4'(MAX_WAIT))) begin
         r_wait <= r_wait + 4'd1;
      end
   end

   // Scoreboard lookup and update; set is applied after clear so set wins
   always_comb begin
      w_ld_oh    = ONE << bus.ld_rd;
      w_lsu_oh   = ONE << bus.lsu_rd;
      w_ld_ready = rstn && ((bus.ld_rd == 5'd0) || ((r_busy & w_ld_oh) == '0) ||
                            (w_gnt_lsu && (bus.lsu_rd == bus.ld_rd)));
      w_ld_set   = bus.ld_issue && w_ld_ready && (bus.ld_rd != 5'd0);
      w_busy_nxt = r_busy;
      if (w_gnt_lsu) w_busy_nxt = w_busy_nxt & ~w_lsu_oh;
      if (w_ld_set)  w_busy_nxt = w_busy_nxt | w_ld_oh;
      w_busy_nxt = w_busy_nxt & ~ONE;
   end

   // Busy-bit register
   always_ff @(posedge clk) begin
      if (!rstn) r_busy <= '0;
      else       r_busy <= w_busy_nxt;
   end

   assign bus.ld_issue_ready = w_ld_ready;
   assign bus.rs1_busy = rstn && ((r_busy & (ONE << bus.rs1_raddr)) != '0);
   assign bus.rs2_busy = rstn && ((r_busy & (ONE << bus.rs2_raddr)) != '0);

   // Register-file write port: granted request lands one cycle later, rd=0 suppresses wen
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_gnt_lsu) begin
         r_wen   <= (bus.lsu_rd != 5'd0);
         r_waddr <= bus.lsu_rd;
         r_wdata <= bus.lsu_data;
      end else if (w_gnt_ex) begin
         r_wen   <= (w_ex_rd != 5'd0);
         r_waddr <= w_ex_rd;
         r_wdata <= w_ex_data;
      end else begin
         r_wen   <= 1'b0;
      end
   end

   assign bus.wen      = r_wen;
   assign bus.rd_waddr = r_waddr;
   assign bus.rd_wdata = r_wdata;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Sequences the register file's single write port between two writeback requesters: the execute unit (EX) and the load/store unit (LSU). Arbitration uses LSU priority, with a starvation guard that forces EX through after a bounded wait. Also holds a per-register load scoreboard, so ID can stall when a source register has a load in flight. Sits between EX/LSU and the register file; its registered outputs drive wen/rd_waddr/rd_wdata.

Parameters:
MAX_WAIT, 4, cycles EX may be refused while valid before it is granted priority (1..15)
NREG, 32, number of architectural registers tracked by the scoreboard

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ex_valid  in  1  EX writeback request
ex_rd  in  5  EX destination register
ex_data  in  32  EX result
ex_ready  out  1  EX request accepted this cycle
lsu_valid  in  1  LSU load-data writeback request
lsu_rd  in  5  LSU destination register
lsu_data  in  32  load data
lsu_ready  out  1  LSU request accepted this cycle
ld_issue  in  1  load being issued to the LSU
ld_rd  in  5  destination register of the issued load
ld_issue_ready  out  1  scoreboard can accept the issued load
rs1_raddr  in  5  ID source-1 address
rs2_raddr  in  5  ID source-2 address
rs1_busy  out  1  rs1 has an outstanding load
rs2_busy  out  1  rs2 has an outstanding load
wen  out  1  register file write enable (registered)
rd_waddr  out  5  register file write address (registered)
rd_wdata  out  32  register file write data (registered)

Behaviour:
- Reset is synchronous on rstn=0. It clears wen, rd_waddr, rd_wdata, the wait counter, and all busy bits. While rstn=0, ex_ready, lsu_ready and ld_issue_ready are 0, and rs1_busy and rs2_busy are 0.
- A handshake completes when valid and ready are both 1 in the same cycle. Ready outputs are combinational from the valid inputs and internal state. A requester holds its rd and data stable until it is accepted.
- Arbitration, one grant per cycle:
  - If the wait counter equals MAX_WAIT and ex_valid=1, EX is granted.
  - Otherwise, if lsu_valid=1, LSU is granted.
  - Otherwise, if ex_valid=1, EX is granted.
- Latency: a request accepted at edge N drives wen=1 with its rd and data during cycle N+1. If there is no grant, wen=0 next cycle, and rd_waddr/rd_wdata hold their previous values.
- rd=0: the request is still accepted (its ready=1 when granted), but the next cycle has wen=0. A rd=0 request consumes the grant slot.
- Wait counter:
  - Increments on each cycle with ex_valid=1 and ex_ready=0, saturating at MAX_WAIT.
  - Clears on EX acceptance.
  - Holds when ex_valid=0.
- Scoreboard (NREG busy bits):
  - ld_issue_ready = (ld_rd==0) or !busy[ld_rd] or (the LSU is accepted this cycle with lsu_rd==ld_rd).
  - On ld_issue && ld_issue_ready && ld_rd!=0, busy[ld_rd] is set.
  - On LSU acceptance, busy[lsu_rd] is cleared.
  - If set and clear hit the same register in the same cycle, set wins.
  - busy[0] is always 0.
- rsX_busy = busy[rsX_raddr]. This is combinational and does not include the write in flight on wen; the register file bypass covers that case.
- An EX write to a register that is busy is legal. The later LSU write overwrites it; in-order ordering is the issuer's responsibility.
- Reset asserted mid-operation drops any pending grant; the next cycle has wen=0.

Optional Feature:
RF_WB_SKID_EN
- Defined: EX gets a one-entry skid buffer.
  - ex_ready = !skid_full, independent of arbitration.
  - A refused EX request is captured in the buffer, and the buffered entry competes as EX under the same rules, wait counter included.
  - While the buffer is full, a scoreboard lookup on its rd is not required.
  - The buffer clears on reset.
- Undefined: ex_ready is the direct arbitration grant, as described above.

Test Plan:
- ex_valid=1, ex_rd=5, ex_data=32'h1234, lsu_valid=0 -> ex_ready=1 in the same cycle; next cycle wen=1, rd_waddr=5, rd_wdata=32'h1234.
- ex_valid and lsu_valid both 1 (lsu_rd=7, lsu_data=32'hAA), MAX_WAIT=4 -> lsu_ready=1 and ex_ready=0; next cycle wen=1, rd_waddr=7.
- lsu_valid held 1 with back-to-back requests, ex_valid held 1 -> LSU is granted for exactly 4 cycles, EX is granted on the 5th, and the counter returns to 0.
- ld_issue with ld_rd=3 -> rs1_busy=1 for rs1_raddr=3 from the next cycle. A second ld_issue with ld_rd=3 sees ld_issue_ready=0. An LSU write with lsu_rd=3 is accepted -> busy clears the cycle after.
- ex_rd=0, ex_valid=1 -> ex_ready=1; next cycle wen=0. ld_issue with ld_rd=0 -> busy never set, and rs1_busy=0 for rs1_raddr=0.
- Busy bits set and a request pending; assert rstn=0 for 1 cycle -> wen=0, all busy bits 0, counter 0; no write to the register file follows.
